// File: rtl/gfifo_sync_param.sv
// gfifo_sync_param: parametrised single-clock FIFO with occupancy, threshold flags, flush and sticky errors
module gfifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     err_clr,
  input  logic                     wr_req_,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_req_,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc     = !rst && !flush && !wr_req_ && !full_q;
    rd_acc     = !rst && !flush && !rd_req_ && !empty_q;
    wptr_d     = flush ? '0 : wptr_q + (AW+1)'(wr_acc);
    rptr_d     = flush ? '0 : rptr_q + (AW+1)'(rd_acc);
    count_d    = wptr_d - rptr_d;
    full_d     = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d    = wptr_d == rptr_d;
    afull_d    = count_d >= (AW+1)'(AFULL_TH);
    aempty_d   = count_d <= (AW+1)'(AEMPTY_TH);
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem[rptr_q[AW-1:0]] : rd_data_q;
    ovf_d      = (!flush && !wr_req_ && full_q) || (ovf_q && !err_clr);
    unf_d      = (!flush && !rd_req_ && empty_q) || (unf_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[AW-1:0]] <= wr_data;
  end
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_gfifo_sync_param.sv
// tb_gfifo_sync_param: table vectors, directed corner sequences and random traffic against a queue model
module tb_gfifo_sync_param;
  logic clk = 0, rst = 0, flush = 0, err_clr = 0, wr_req_ = 1, rd_req_ = 1;
  logic [7:0] wr_data = 0, rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  logic m_ovf = 0, m_unf = 0, m_rv = 0;
  logic [7:0] m_rd = 0;
  typedef struct {
    logic r, f, ec, wn;
    logic [7:0] wd;
    logic rn;
    int cnt;
    logic efull, eempty, eaf, eae, erv, eovf, eunf;
    logic [7:0] erd;
  } vec_t;
  vec_t tbl[$];

  gfifo_sync_param #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .wr_req_(wr_req_),
    .wr_data(wr_data), .rd_req_(rd_req_), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  task automatic step(input logic r, f, ec, wn, input logic [7:0] wd, input logic rn);
    logic fb, eb;
    rst = r; flush = f; err_clr = ec; wr_req_ = wn; wr_data = wd; rd_req_ = rn;
    @(posedge clk);
    fb = q.size() == 8;
    eb = q.size() == 0;
    if (r) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 0;
    end else if (f) begin
      q.delete(); m_rv = 0;
      if (ec) begin m_ovf = 0; m_unf = 0; end
    end else begin
      m_ovf = (!wn && fb) || (m_ovf && !ec);
      m_unf = (!rn && eb) || (m_unf && !ec);
      m_rv = !rn && !eb;
      if (m_rv) m_rd = q.pop_front();
      if (!wn && !fb) q.push_back(wd);
    end
    #1;
    vectors++;
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    rst = 0; flush = 0; err_clr = 0; wr_req_ = 1; rd_req_ = 1;
  endtask

  task automatic add(input logic r, f, ec, wn, input logic [7:0] wd, input logic rn,
                     input int cnt, input logic erv, input logic [7:0] erd, input logic eovf, eunf);
    vec_t v;
    v.r = r; v.f = f; v.ec = ec; v.wn = wn; v.wd = wd; v.rn = rn; v.cnt = cnt;
    v.efull = cnt == 8; v.eempty = cnt == 0; v.eaf = cnt >= 6; v.eae = cnt <= 2;
    v.erv = erv; v.erd = erd; v.eovf = eovf; v.eunf = eunf;
    tbl.push_back(v);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, base + 8'(i), 1);
  endtask

  initial begin
    add(1, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 8'(8'h11 * k), 1, k, 0, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'hFF, 1, 8, 0, 8'h00, 1, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 0, 0, 8 - k, 1, 8'(8'h11 * k), 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 8'h88, 1, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 8'h88, 0, 0);
    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].ec, tbl[i].wn, tbl[i].wd, tbl[i].rn);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_full", 32'(full), 32'(tbl[i].efull));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].eempty));
      chk("tbl_afull", 32'(almost_full), 32'(tbl[i].eaf));
      chk("tbl_aempty", 32'(almost_empty), 32'(tbl[i].eae));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].erv));
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].erd));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].eovf));
      chk("tbl_underflow", 32'(underflow), 32'(tbl[i].eunf));
    end
    // wrap: pointers cross DEPTH before the second fill
    step(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'(i), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
    fill(8'hA0);
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("wrap_data", 32'(rd_data), 32'(8'hA0 + 8'(i)));
    end
    // simultaneous read/write at count 3, at full and at empty
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'(8'h30 + i), 1);
    step(0, 0, 0, 0, 8'h33, 0);
    chk("sim_cnt3", 32'(count), 32'd3);
    step(1, 0, 0, 1, 0, 1);
    fill(8'h40);
    step(0, 0, 0, 0, 8'hEE, 0);
    chk("sim_full_cnt", 32'(count), 32'd7);
    chk("sim_full_ovf", 32'(overflow), 32'd1);
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 8'h55, 0);
    chk("sim_empty_cnt", 32'(count), 32'd1);
    chk("sim_empty_unf", 32'(underflow), 32'd1);
    chk("sim_empty_rv", 32'(rd_valid), 32'd0);
    // flush then reset mid-stream with overflow set
    step(1, 0, 0, 1, 0, 1);
    fill(8'h60);
    step(0, 0, 0, 0, 8'hFF, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    chk("fl_pre_cnt", 32'(count), 32'd4);
    step(0, 1, 0, 0, 8'h01, 0);
    chk("fl_cnt", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd1);
    chk("fl_rd", 32'(rd_data), 32'h63);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 8'(8'h70 + i), 1);
    step(1, 0, 0, 1, 0, 1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      int p = $urandom_range(0, 99);
      int wbias = (i / 300) % 2 ? 70 : 35;
      step(p == 0, p == 1, p < 4, $urandom_range(0, 99) >= wbias, 8'($urandom),
           $urandom_range(0, 99) >= 100 - wbias);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
